reg_file: RTL and testbench

Register bank that feeds the `ula` operand inputs `a` and `b`. It holds 32 general-purpose registers, each 64 bits wide, in two's complement. Register x0 is hardwired to zero. The bank has one synchronous write port and two registered read ports with write-to-read bypass, so a value written in cycle N is visible as an ALU operand at the start of cycle N+1. Registered outputs and a `valid` strobe tell the execute stage when `a`/`b` carry freshly read operands.

---
 rtl/reg_file.sv | 97 +++++++++
 tb/tb_reg_file.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// -----------------------------------------------------------------------------
// reg_file
//
// Operand register bank for the `ula` execute stage. It holds REGS words of
// BITS+1 bits. x0 is a constant zero and is never stored.
//
// It has one synchronous write port and two registered read ports. Each read
// port has a write-to-read bypass, so a write on edge N is visible as an
// operand on edge N as well. The stored value is then readable from edge N+1.
//
// Ports
//   clk    rising-edge clock
//   reset  asynchronous, active-high; clears storage and outputs
//   we     write enable (sampled on posedge clk)
//   wa     write address (a write to x0 is ignored)
//   wd     write data
//   re     read enable (sampled on posedge clk)
//   rs1    read address for operand a
//   rs2    read address for operand b
//   a      registered operand a (to ula.a)
//   b      registered operand b (to ula.b)
//   valid  one-cycle strobe: a/b hold freshly read operands
//
// Handshake: there is no back-pressure. Every edge with re=1 is an accepted
// read. One edge later, valid=1 and a/b carry that read's operands. On an edge
// with re=0, valid drops to 0 and a/b keep their last values.
// -----------------------------------------------------------------------------
module reg_file #(
    parameter int BITS = 63,
    parameter int REGS = 32,
    parameter int ADDR = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            we,
    input  logic [ADDR-1:0] wa,
    input  logic [BITS:0]   wd,
    input  logic            re,
    input  logic [ADDR-1:0] rs1,
    input  logic [ADDR-1:0] rs2,
    output logic [BITS:0]   a,
    output logic [BITS:0]   b,
    output logic            valid
);

    // Entry 0 is deliberately absent: x0 has no storage at all.
    logic [BITS:0] mem [1:REGS-1];

    logic [BITS:0] src1;
    logic [BITS:0] src2;

    // Operand source selection. x0 takes priority over the bypass, so a
    // same-edge write to x0 can never leak into an operand.
    always_comb begin
        src1 = '0;
        if (rs1 != '0) begin
            if (we && (wa == rs1)) src1 = wd;
            else                   src1 = mem[rs1];
        end
    end

    always_comb begin
        src2 = '0;
        if (rs2 != '0) begin
            if (we && (wa == rs2)) src2 = wd;
            else                   src2 = mem[rs2];
        end
    end

    // Storage write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 1; i < REGS; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (wa != '0)) begin
            mem[wa] <= wd;
        end
    end

    // Registered read ports. Operands hold while re=0, so ula keeps a
    // stable input between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a     <= '0;
            b     <= '0;
            valid <= 1'b0;
        end else begin
            valid <= re;
            if (re) begin
                a <= src1;
                b <= src2;
            end
        end
    end

endmodule

// File: tb/tb_reg_file.sv
module tb_reg_file;
    localparam int BITS = 63;
    localparam int REGS = 32;
    localparam int ADDR = 5;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic            we;
    logic [ADDR-1:0] wa;
    logic [BITS:0]   wd;
    logic            re;
    logic [ADDR-1:0] rs1;
    logic [ADDR-1:0] rs2;
    logic [BITS:0]   a;
    logic [BITS:0]   b;
    logic            valid;

    reg_file #(.BITS(BITS), .REGS(REGS), .ADDR(ADDR)) dut (
        .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd), .re(re),
        .rs1(rs1), .rs2(rs2), .a(a), .b(b), .valid(valid)
    );

    // ---------------- reference model ----------------
    logic [BITS:0] model_mem [REGS];
    logic [BITS:0] model_a;
    logic [BITS:0] model_b;
    logic          model_valid;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < REGS; i++) model_mem[i] = '0;
        model_a = '0;
        model_b = '0;
        model_valid = 1'b0;
    endtask

    function automatic logic [BITS:0] model_src(input int r, input logic w, input int waddr,
                                                input logic [BITS:0] wdata);
        if (r == 0) return '0;
        if (w && waddr == r) return wdata;
        return model_mem[r];
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, ".a"}, a, model_a);
        check_val({tag, ".b"}, b, model_b);
        check_val({tag, ".valid"}, {63'd0, valid}, {63'd0, model_valid});
    endtask

    // ---------------- driver ----------------
    // One clock cycle: drive at negedge, the model steps at posedge, and
    // outputs are sampled 1 time unit after the edge.
    task automatic step(input logic we_i, input int wa_i, input logic [BITS:0] wd_i,
                        input logic re_i, input int rs1_i, input int rs2_i, input string tag);
        logic [BITS:0] na;
        logic [BITS:0] nb;
        @(negedge clk);
        we = we_i; wa = ADDR'(wa_i); wd = wd_i;
        re = re_i; rs1 = ADDR'(rs1_i); rs2 = ADDR'(rs2_i);
        @(posedge clk);
        if (re_i) begin
            na = model_src(rs1_i, we_i, wa_i, wd_i);
            nb = model_src(rs2_i, we_i, wa_i, wd_i);
            model_a = na;
            model_b = nb;
            model_valid = 1'b1;
        end else begin
            model_valid = 1'b0;
        end
        if (we_i && wa_i != 0) model_mem[wa_i] = wd_i;
        #1;
        check_outputs(tag);
    endtask

    // Asynchronous reset pulse placed between clock edges. Edges while it is
    // held high carry random write/read traffic that must be ignored.
    task automatic pulse_reset(input int edges);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_clear();
        check_outputs("reset_async");
        for (int i = 0; i < edges; i++) begin
            we = 1'b1; wa = ADDR'($urandom_range(1, REGS - 1)); wd = {$urandom, $urandom};
            re = 1'b1; rs1 = ADDR'($urandom_range(0, REGS - 1)); rs2 = wa;
            @(posedge clk);
            #1;
            check_outputs("reset_held");
        end
        @(negedge clk);
        we = 1'b0; re = 1'b0;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [BITS:0] held_a;
        logic [BITS:0] held_b;
        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; re = 1'b0; rs1 = '0; rs2 = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("por");
        @(negedge clk);
        reset = 1'b0;

        // Reset state: write reg[5], reset mid-run, then read it back as 0.
        step(1, 5, 64'h1234, 0, 0, 0, "w5");
        step(0, 0, 0, 1, 5, 0, "r5_pre");
        check_val("r5_pre_const", a, 64'h1234);
        pulse_reset(2);
        step(0, 0, 0, 1, 5, 0, "r5_post");
        check_val("r5_post_const", a, 64'h0);

        // Write then read the same register on both ports.
        step(1, 3, 64'h7FFF_FFFF_FFFF_FFFF, 0, 0, 0, "w3");
        step(0, 0, 0, 1, 3, 3, "r3");
        check_val("r3_a_const", a, 64'h7FFF_FFFF_FFFF_FFFF);
        check_val("r3_b_const", b, 64'h7FFF_FFFF_FFFF_FFFF);

        // Same-edge bypass.
        step(1, 7, 64'd5, 0, 0, 0, "w7");
        step(1, 7, 64'hFFFF_FFFF_FFFF_FFFE, 1, 7, 7, "bypass7");
        check_val("bypass_a_const", a, 64'hFFFF_FFFF_FFFF_FFFE);
        check_val("bypass_b_const", b, 64'hFFFF_FFFF_FFFF_FFFE);

        // x0 protection, both on the same edge and on the following edge.
        step(1, 0, 64'hDEAD, 1, 0, 0, "x0_same");
        check_val("x0_same_const", a, 64'h0);
        step(0, 0, 0, 1, 0, 0, "x0_next");
        check_val("x0_next_const", b, 64'h0);

        // Hold: operands stay put while re=0 and addresses/storage change.
        step(0, 0, 0, 1, 3, 7, "hold_rd");
        held_a = a; held_b = b;
        check_val("hold_rd_a_const", held_a, 64'h7FFF_FFFF_FFFF_FFFF);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 64'hA5A5_0000_0000_0000 + 64'(i), 0, i + 1, i + 9, "hold");
            check_val("hold_a_const", a, held_a);
            check_val("hold_b_const", b, held_b);
        end

        // Back-to-back reads over preloaded 1..4.
        for (int i = 1; i <= 4; i++) step(1, i, 64'(10 * i), 0, 0, 0, "preload");
        for (int i = 1; i <= 4; i++) begin
            step(0, 0, 0, 1, i, 5 - i, "b2b");
            check_val("b2b_a_const", a, 64'(10 * i));
        end

        // Randomized traffic, biased toward address collisions.
        for (int n = 0; n < 400; n++) begin
            int w_addr;
            int r1;
            int r2;
            w_addr = $urandom_range(0, REGS - 1);
            r1 = ($urandom_range(0, 3) == 0) ? w_addr : $urandom_range(0, REGS - 1);
            r2 = ($urandom_range(0, 3) == 0) ? r1 : $urandom_range(0, REGS - 1);
            step(1'($urandom_range(0, 1)), w_addr, {$urandom, $urandom},
                 1'($urandom_range(0, 3) != 0), r1, r2, "rand");
            if (n == 200) pulse_reset($urandom_range(1, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
